// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM states and command record layout for the ALU issue sequencer
package alu_seq_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_TAG_W = 4;
  localparam int OP_W = 3;
  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MULT = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_DIV = 3'd4;
  localparam logic [OP_W-1:0] OP_MOD = 3'd5;
  localparam logic [OP_W-1:0] OP_LT = 3'd6;
  localparam logic [OP_W-1:0] OP_LE = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_RESPOND} state_t;
  // Command record packs {op, a, b, tag} with the tag in the low bits.
  localparam int CMD_TAG_LSB = 0;
  function automatic int cmd_b_lsb(input int tag_w);
    return tag_w;
  endfunction
  function automatic int cmd_a_lsb(input int width, input int tag_w);
    return tag_w + width;
  endfunction
  function automatic int cmd_op_lsb(input int width, input int tag_w);
    return tag_w + 2 * width;
  endfunction
  function automatic int cmd_w(input int width, input int tag_w);
    return tag_w + 2 * width + OP_W;
  endfunction
endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with full/empty/count, synchronous active-low reset
module alu_cmd_fifo #(
  parameter int WIDTH = 39,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic w_push, w_pop;
  assign o_full = r_count == CNT_W'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data = r_mem[r_rd];
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
  // Storage needs no reset; occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: queues ALU commands, drives the ALU one op at a time, returns tagged results.
// Optional macro ALU_DIVZERO_GUARD_EN short-circuits DIV/MOD by zero to an error response.
module alu_issue_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alu_operator,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);
  localparam int CW = cmd_w(WIDTH, TAG_W);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int B_LSB = cmd_b_lsb(TAG_W);
  localparam int A_LSB = cmd_a_lsb(WIDTH, TAG_W);
  localparam int OP_LSB = cmd_op_lsb(WIDTH, TAG_W);
  logic w_push, w_pop, w_full, w_empty, w_dz;
  logic [CW-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic [OP_W-1:0] w_op;
  logic [WIDTH-1:0] w_a, w_b;
  logic [TAG_W-1:0] w_tag;
  state_t r_state, w_next;
  logic [2:0] r_operator;
  logic [WIDTH-1:0] r_op1, r_op2, r_rsp_data;
  logic [TAG_W-1:0] r_rsp_tag, r_cmd_tag;
  logic r_rsp_err;
  alu_cmd_fifo #(.WIDTH(CW), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_data({cmd_op, cmd_a, cmd_b, cmd_tag}),
    .i_pop(w_pop),
    .o_data(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );
  assign w_tag = w_head[CMD_TAG_LSB +: TAG_W];
  assign w_b = w_head[B_LSB +: WIDTH];
  assign w_a = w_head[A_LSB +: WIDTH];
  assign w_op = w_head[OP_LSB +: OP_W];
  assign cmd_ready = !w_full;
  assign w_push = cmd_valid && !w_full;
  assign w_pop = (r_state == ST_IDLE) && !w_empty;
`ifdef ALU_DIVZERO_GUARD_EN
  assign w_dz = ((w_op == OP_DIV) || (w_op == OP_MOD)) && (w_b == '0);
`else
  assign w_dz = 1'b0;
`endif
  assign alu_operator = r_operator;
  assign alu_op1 = r_op1;
  assign alu_op2 = r_op2;
  assign rsp_valid = r_state == ST_RESPOND;
  assign rsp_data = r_rsp_data;
  assign rsp_tag = r_rsp_tag;
  assign rsp_err = r_rsp_err;
  assign busy = (w_count != '0) || (r_state != ST_IDLE);
  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  // Next-state: IDLE pops, DRIVE lasts one cycle, RESPOND waits for the consumer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: w_next = w_empty ? ST_IDLE : (w_dz ? ST_RESPOND : ST_DRIVE);
      ST_DRIVE: w_next = ST_RESPOND;
      ST_RESPOND: w_next = rsp_ready ? ST_IDLE : ST_RESPOND;
      default: w_next = ST_IDLE;
    endcase
  end
  // ALU drive and response registers; SUB swaps operands because the ALU computes op2 - op1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_operator <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_cmd_tag <= '0;
      r_rsp_data <= '0;
      r_rsp_tag <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_pop && !w_dz) begin
        r_operator <= w_op;
        r_op1 <= (w_op == OP_SUB) ? w_b : w_a;
        r_op2 <= (w_op == OP_SUB) ? w_a : w_b;
        r_cmd_tag <= w_tag;
      end
      if (w_pop && w_dz) begin
        r_rsp_data <= '1;
        r_rsp_tag <= w_tag;
        r_rsp_err <= 1'b1;
      end
      if (r_state == ST_DRIVE) begin
        r_rsp_data <= alu_out;
        r_rsp_tag <= r_cmd_tag;
        r_rsp_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_seq.sv
// tb_alu_issue_seq: table-driven check of alu_issue_seq against a behavioural ALU model
module tb_alu_issue_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1, rsp_err, busy;
  logic [2:0] cmd_op = '0, alu_operator;
  logic [15:0] cmd_a = '0, cmd_b = '0, alu_op1, alu_op2, alu_out, rsp_data;
  logic [3:0] cmd_tag = '0, rsp_tag;
  logic [31:0] prod;
  int n_vec = 0, n_bad = 0;
  typedef struct {
    logic [2:0] op;
    logic [15:0] a, b;
    logic [3:0] tag;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[13];
  always #5 clk = ~clk;
  alu_issue_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_operator(alu_operator), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );
  // Behavioural 16-bit ALU: SUB yields op2 - op1, everything else op1 <op> op2.
  assign prod = {16'h0, alu_op1} * {16'h0, alu_op2};
  always_comb begin
    alu_out = '0;
    case (alu_operator)
      3'd0: alu_out = alu_op1 + alu_op2;
      3'd1: alu_out = alu_op2 - alu_op1;
      3'd2: alu_out = prod[15:0];
      3'd3: alu_out = ~(alu_op1 & alu_op2);
      3'd4: alu_out = (alu_op2 == 0) ? 16'hFFFF : alu_op1 / alu_op2;
      3'd5: alu_out = (alu_op2 == 0) ? alu_op1 : alu_op1 % alu_op2;
      3'd6: alu_out = {15'h0, alu_op1 < alu_op2};
      default: alu_out = {15'h0, alu_op1 <= alu_op2};
    endcase
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag);
    int k = 0;
    @(negedge clk);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_valid = 1'b1;
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
  endtask
  initial begin
    int n, hits;
    logic [15:0] p1, p2;
    vecs[0]  = '{3'd0, 16'd3, 16'd5, 4'd1, 16'd8};
    vecs[1]  = '{3'd1, 16'd10, 16'd3, 4'd2, 16'd7};
    vecs[2]  = '{3'd1, 16'd3, 16'd10, 4'd3, 16'hFFF9};
    vecs[3]  = '{3'd2, 16'h0100, 16'h0100, 4'd4, 16'h0000};
    vecs[4]  = '{3'd3, 16'hFFFF, 16'h00FF, 4'd5, 16'hFF00};
    vecs[5]  = '{3'd6, 16'hFFFF, 16'h0001, 4'd6, 16'd0};
    vecs[6]  = '{3'd7, 16'd7, 16'd7, 4'd7, 16'd1};
    vecs[7]  = '{3'd5, 16'd17, 16'd5, 4'd8, 16'd2};
    vecs[8]  = '{3'd4, 16'd17, 16'd5, 4'd10, 16'd3};
    vecs[9]  = '{3'd6, 16'h0001, 16'hFFFF, 4'd11, 16'd1};
    vecs[10] = '{3'd4, 16'd100, 16'd7, 4'd12, 16'd14};
    vecs[11] = '{3'd5, 16'd5, 16'd17, 4'd13, 16'd5};
    vecs[12] = '{3'd2, 16'd300, 16'd300, 4'd14, 16'h5F90};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu", {alu_operator, alu_op1}, 0);
    chk("rst_alu_op2", alu_op2, 0);
    chk("rst_rsp", {rsp_err, rsp_tag, rsp_data}, 0);
    rst = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_rsp(n);
      chk($sformatf("v%0d_latency", i), n, 2);
      chk($sformatf("v%0d_data", i), rsp_data, vecs[i].data);
      chk($sformatf("v%0d_tag", i), rsp_tag, vecs[i].tag);
      chk($sformatf("v%0d_err", i), rsp_err, 0);
      chk($sformatf("v%0d_op1", i), alu_op1, (vecs[i].op == 3'd1) ? vecs[i].b : vecs[i].a);
      chk($sformatf("v%0d_op2", i), alu_op2, (vecs[i].op == 3'd1) ? vecs[i].a : vecs[i].b);
      @(negedge clk);
    end
    p1 = alu_op1;
    p2 = alu_op2;
    send(3'd4, 16'd7, 16'd0, 4'd9);
    wait_rsp(n);
`ifdef ALU_DIVZERO_GUARD_EN
    chk("dz_latency", n, 1);
    chk("dz_err", rsp_err, 1);
    chk("dz_op1_held", alu_op1, p1);
    chk("dz_op2_held", alu_op2, p2);
`else
    chk("dz_latency", n, 2);
    chk("dz_err", rsp_err, 0);
    chk("dz_op1", alu_op1, 16'd7);
    chk("dz_op2", alu_op2, 16'd0);
`endif
    chk("dz_data", rsp_data, 16'hFFFF);
    chk("dz_tag", rsp_tag, 9);
    @(negedge clk);
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_op = (i % 3 == 0) ? 3'd0 : (i % 3 == 1) ? 3'd2 : 3'd3;
      cmd_a = (i == 0) ? 16'd1 : (i == 1) ? 16'h0100 : (i == 2) ? 16'hFFFF : (i == 3) ? 16'hFFFF : 16'd3;
      cmd_b = (i == 0) ? 16'd2 : (i == 1) ? 16'h0100 : (i == 2) ? 16'h00FF : (i == 3) ? 16'd2 : 16'd4;
      cmd_tag = 4'(i);
      cmd_valid = 1'b1;
      chk($sformatf("bp_ready%0d", i), cmd_ready, (i < 5) ? 1 : 0);
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("bp_hold_valid", rsp_valid, 1);
    chk("bp_hold_data", rsp_data, 16'd3);
    chk("bp_hold_tag", rsp_tag, 0);
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_rsp(n);
      chk($sformatf("bp%0d_valid", j), rsp_valid, 1);
      chk($sformatf("bp%0d_tag", j), rsp_tag, j);
      chk($sformatf("bp%0d_data", j), rsp_data,
          (j == 0) ? 16'd3 : (j == 1) ? 16'h0000 : (j == 2) ? 16'hFF00 : (j == 3) ? 16'h0001 : 16'd12);
      @(negedge clk);
    end
    hits = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    chk("bp_no_extra", hits, 0);
    chk("bp_idle_busy", busy, 0);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_op = 3'd0; cmd_a = 16'(i); cmd_b = 16'd1; cmd_tag = 4'(i); cmd_valid = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("mr_pre_valid", rsp_valid, 1);
    chk("mr_pre_busy", busy, 1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("mr_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    chk("mr_rsp_data", rsp_data, 0);
    rsp_ready = 1'b1;
    hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid) hits++;
    end
    chk("mr_no_stale", hits, 0);
    chk("mr_busy_after", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
